// File: rtl/seq_add_sub_unit_if.sv
// Handshake and operand/result bundle for the chunked add/subtract unit.
// The master drives operands and accepts results; the slave is the unit.
interface seq_add_sub_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             op_sub;
    logic             op_sat;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, op_sub, op_sat, a, b, out_ready,
        input  in_ready, out_valid, result, carry, overflow, zero
    );

    modport slave (
        input  in_valid, op_sub, op_sat, a, b, out_ready,
        output in_ready, out_valid, result, carry, overflow, zero
    );
endinterface

// File: rtl/seq_add_sub_unit.sv
// Multi-cycle add/subtract: CHUNK bits per clock with a registered carry,
// optional signed saturation, and carry/overflow/zero flags.
module seq_add_sub_unit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input logic              clk,
    input logic              rst,
    seq_add_sub_unit_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if ((WIDTH < 2) || (CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_cfg
        $error("seq_add_sub_unit: WIDTH must be >=2 and a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cin_q, cin_d;
    logic             sat_q, sat_d;
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [CHUNK:0]   csum;
    logic [WIDTH-1:0] sum_nx;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sat_val;
    logic [WIDTH-1:0] fin_res;
    logic             ovf_w;
    logic             last;

    // Operands shift right each cycle so the adder always sees bit 0;
    // finished chunks enter the sum register from the top.
    always_comb begin
        csum    = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                + {{CHUNK{1'b0}}, cin_q};
        sum_nx  = (sum_q >> CHUNK)
                | (WIDTH'(csum[CHUNK-1:0]) << (WIDTH - CHUNK));
        b_eff   = bus.op_sub ? ~bus.b : bus.b;
        last    = (cnt_q == CW'(NCHUNK - 1));
        ovf_w   = (amsb_q == bmsb_q) && (sum_nx[WIDTH-1] != amsb_q);
        sat_val = amsb_q ? {1'b1, {(WIDTH-1){1'b0}}}
                         : {1'b0, {(WIDTH-1){1'b1}}};
        fin_res = (sat_q && ovf_w) ? sat_val : sum_nx;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cin_d   = cin_q;
        sat_d   = sat_q;
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        res_d   = res_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = b_eff;
                    cin_d   = bus.op_sub;
                    sat_d   = bus.op_sat;
                    amsb_d  = bus.a[WIDTH-1];
                    bmsb_d  = b_eff[WIDTH-1];
                    sum_d   = '0;
                    cnt_d   = '0;
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                a_d   = a_q >> CHUNK;
                b_d   = b_q >> CHUNK;
                cin_d = csum[CHUNK];
                sum_d = sum_nx;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    res_d   = fin_res;
                    carry_d = csum[CHUNK];
                    ovf_d   = ovf_w;
                    zero_d  = (fin_res == '0);
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cin_q   <= 1'b0;
            sat_q   <= 1'b0;
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            res_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cin_q   <= cin_d;
            sat_q   <= sat_d;
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = res_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_seq_add_sub_unit.sv
// Scoreboard bench for seq_add_sub_unit: CHUNK=8 and CHUNK=32 instances
// checked against a plain-arithmetic reference model.
module tb_seq_add_sub_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_add_sub_unit_if #(.WIDTH(32)) ia ();
    seq_add_sub_unit_if #(.WIDTH(32)) ib ();

    seq_add_sub_unit #(.WIDTH(32), .CHUNK(8)) dut_a (
        .clk(clk), .rst(rst), .bus(ia.slave)
    );
    seq_add_sub_unit #(.WIDTH(32), .CHUNK(32)) dut_b (
        .clk(clk), .rst(rst), .bus(ib.slave)
    );

    typedef struct {
        logic [31:0] res;
        logic        c;
        logic        o;
        logic        z;
        int          acc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   seen_a = 0;
    bit   seen_b = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(logic [31:0] a, logic [31:0] b,
                                   logic sub, logic sat);
        exp_t   m;
        longint sa, sb, ua, ub, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        if (sub) begin
            s   = sa - sb;
            m.c = (ua >= ub);
        end else begin
            s   = sa + sb;
            m.c = ((ua + ub) > 64'hFFFF_FFFF);
        end
        m.o   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        m.res = s[31:0];
        if (sat && m.o) m.res = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        m.z   = (m.res == 32'h0);
        m.acc = 0;
        return m;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic score(string tag, exp_t e, logic [31:0] r, logic c,
                         logic o, logic z, int lat, int nch);
        chk({tag, ".result"}, r, e.res);
        chk({tag, ".carry"}, 32'(c), 32'(e.c));
        chk({tag, ".overflow"}, 32'(o), 32'(e.o));
        chk({tag, ".zero"}, 32'(z), 32'(e.z));
        chk({tag, ".latency"}, lat, nch);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            seen_a = 0;
            seen_b = 0;
        end else begin
            if (ia.out_valid && !seen_a) begin
                seen_a = 1;
                if (qa.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL a.unexpected: got output want none");
                end else begin
                    score("a", qa[0], ia.result, ia.carry, ia.overflow,
                          ia.zero, cyc - qa[0].acc, 4);
                end
            end
            if (ia.out_valid && ia.out_ready) begin
                seen_a = 0;
                if (qa.size() > 0) void'(qa.pop_front());
            end
            if (ib.out_valid && !seen_b) begin
                seen_b = 1;
                if (qb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL b.unexpected: got output want none");
                end else begin
                    score("b", qb[0], ib.result, ib.carry, ib.overflow,
                          ib.zero, cyc - qb[0].acc, 1);
                end
            end
            if (ib.out_valid && ib.out_ready) begin
                seen_b = 0;
                if (qb.size() > 0) void'(qb.pop_front());
            end
        end
    end

    // Called just after a rising edge; returns just after the accept edge.
    task automatic issue(bit sel, logic [31:0] a, logic [31:0] b,
                         logic sub, logic sat);
        int   n = 0;
        exp_t e;
        while (!(sel ? ib.in_ready : ia.in_ready) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) chk("issue.timeout", 32'(n), 32'd0);
        e = model(a, b, sub, sat);
        e.acc = cyc + 1;
        if (sel) begin
            ib.in_valid = 1; ib.a = a; ib.b = b;
            ib.op_sub = sub; ib.op_sat = sat;
            qb.push_back(e);
        end else begin
            ia.in_valid = 1; ia.a = a; ia.b = b;
            ia.op_sub = sub; ia.op_sat = sat;
            qa.push_back(e);
        end
        @(posedge clk);
        #1;
        if (sel) begin
            ib.in_valid = 0; ib.a = $urandom; ib.b = $urandom;
            ib.op_sub = ~sub; ib.op_sat = ~sat;
        end else begin
            ia.in_valid = 0; ia.a = $urandom; ia.b = $urandom;
            ia.op_sub = ~sub; ia.op_sat = ~sat;
        end
    endtask

    task automatic drain(bit sel);
        int n = 0;
        while ((sel ? qb.size() : qa.size()) > 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 500) chk("drain.timeout", 32'(n), 32'd0);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] edges [6];
        edges[0] = 32'h0;        edges[1] = 32'h1;
        edges[2] = 32'h7FFF_FFFF; edges[3] = 32'h8000_0000;
        edges[4] = 32'hFFFF_FFFF; edges[5] = 32'h0000_00FF;
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e1;
        int   n;
        rst = 1;
        ia.in_valid = 0; ia.out_ready = 1; ia.op_sub = 0; ia.op_sat = 0;
        ia.a = 0; ia.b = 0;
        ib.in_valid = 0; ib.out_ready = 1; ib.op_sub = 0; ib.op_sat = 0;
        ib.a = 0; ib.b = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.in_ready", 32'(ia.in_ready), 32'd1);
        chk("rst.out_valid", 32'(ia.out_valid), 32'd0);
        chk("rst.result", ia.result, 32'd0);
        chk("rst.flags", {29'd0, ia.carry, ia.overflow, ia.zero}, 32'd0);
        rst = 0;
        @(posedge clk);
        #1;

        issue(0, 32'd100, 32'd23, 0, 0);
        issue(0, 32'd5, 32'd7, 1, 0);
        issue(0, 32'd7, 32'd7, 1, 0);
        issue(0, 32'h7FFF_FFFF, 32'd1, 0, 0);
        issue(0, 32'h7FFF_FFFF, 32'd1, 0, 1);
        issue(0, 32'h8000_0000, 32'd1, 1, 1);
        issue(0, 32'h8000_0000, 32'h8000_0000, 0, 1);
        issue(0, 32'h0000_00FF, 32'd1, 0, 0);
        issue(0, 32'hFFFF_FFFF, 32'd1, 0, 0);
        drain(0);

        // Result held under back-pressure; offered op must be ignored.
        ia.out_ready = 0;
        e1 = model(32'h1234, 32'h0111, 0, 0);
        issue(0, 32'h1234, 32'h0111, 0, 0);
        n = 0;
        while (!ia.out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) chk("hold.timeout", 32'(n), 32'd0);
        repeat (5) begin
            ia.in_valid = 1; ia.a = 32'd9; ia.b = 32'd9;
            ia.op_sub = 0; ia.op_sat = 0;
            @(negedge clk);
            chk("hold.in_ready", 32'(ia.in_ready), 32'd0);
            chk("hold.out_valid", 32'(ia.out_valid), 32'd1);
            chk("hold.result", ia.result, e1.res);
            @(posedge clk);
            #1;
        end
        ia.in_valid = 0;
        ia.out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        chk("release.in_ready", 32'(ia.in_ready), 32'd1);
        chk("release.out_valid", 32'(ia.out_valid), 32'd0);
        @(posedge clk);
        #1;
        issue(0, 32'd9, 32'd9, 0, 0);
        drain(0);

        for (int i = 0; i < 40; i++) begin
            issue(0, pick(), pick(), 1'($urandom), 1'($urandom));
        end
        drain(0);

        // Reset in the middle of a CHUNK=8 operation.
        issue(0, 32'hDEAD_0000, 32'h0000_BEEF, 0, 0);
        drain(0);
        issue(0, 32'h1234_5678, 32'd1, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1;
        qa.delete();
        #1;
        chk("midrst.out_valid", 32'(ia.out_valid), 32'd0);
        chk("midrst.in_ready", 32'(ia.in_ready), 32'd1);
        chk("midrst.result", ia.result, 32'd0);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        issue(0, 32'd1, 32'd1, 0, 0);
        drain(0);

        // Single-cycle configuration.
        issue(1, 32'd100, 32'd23, 0, 0);
        drain(1);
        issue(1, 32'h1234_5678, 32'd1, 0, 0);
        rst = 1;
        qb.delete();
        #1;
        chk("b.midrst.out_valid", 32'(ib.out_valid), 32'd0);
        chk("b.midrst.in_ready", 32'(ib.in_ready), 32'd1);
        chk("b.midrst.result", ib.result, 32'd0);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        issue(1, 32'd1, 32'd1, 0, 0);
        for (int i = 0; i < 15; i++) begin
            issue(1, pick(), pick(), 1'($urandom), 1'($urandom));
        end
        drain(1);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
